// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
// Holds the fetch queue entry layout and its constants.
package pipeline_types;

  localparam int EXC_CAUSE_W = 7;
  localparam int EXC_FLAGS = 5;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic [31:0]                      pc;
    logic [31:0]                      inst;
    logic [EXC_FLAGS-1:0]             is_exception;
    logic [EXC_FLAGS*EXC_CAUSE_W-1:0] exception_cause;
  } fetch_entry_t;

  typedef enum logic {
    NORMAL,
    EXC_HOLD
  } fb_state_t;

endpackage

// File: rtl/inst_fetch_buffer_mem.sv
// Entry storage for the fetch buffer.
// Registered write, cleared on reset, combinational read.
module fetch_buffer_mem
  import pipeline_types::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  // write one entry per cycle; reset wipes every slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode decoupling queue.
// Holds fetches after a faulting PC until flush.
module inst_fetch_buffer
  import pipeline_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic [4:0]               in_is_exception,
  input  logic [34:0]              in_exception_cause,
  output logic                     in_ready,
  output logic                     pause_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [4:0]               out_is_exception,
  output logic [34:0]              out_exception_cause,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  fb_state_t     state;
  fb_state_t     state_nx;
  fetch_entry_t  wdata;
  fetch_entry_t  rdata;
  logic          push;
  logic          pop;
  logic          has_exc;

  assign has_exc   = |in_is_exception;
  assign in_ready  = (cnt != CW'(DEPTH)) & (state == NORMAL);
  assign out_valid = (cnt != '0) & ~flush;
  assign pause_req = (cnt >= CW'(DEPTH - 1)) | (state == EXC_HOLD);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  // faulting fetches carry a NOP so ID never decodes garbage
  always_comb begin
    wdata                 = '0;
    wdata.pc              = in_pc;
    wdata.inst            = has_exc ? NOP_INST : in_inst;
    wdata.is_exception    = in_is_exception;
    wdata.exception_cause = in_exception_cause;
  end

  // circular pointers and occupancy; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nx;
  end

  // enter hold on a faulting push, leave on flush
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      flush:          state_nx = NORMAL;
      push & has_exc: state_nx = EXC_HOLD;
      default:        state_nx = state;
    endcase
  end

  fetch_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out_pc              = rdata.pc;
  assign out_inst            = rdata.inst;
  assign out_is_exception    = rdata.is_exception;
  assign out_exception_cause = rdata.exception_cause;

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Decoupling queue between the PC/instruction-fetch stage and ID. Each entry holds a PC, the instruction returned by the instruction ROM, and the fetch-side exception flags and causes. The queue absorbs decode stalls with a valid/ready handshake and raises an early pause request so the PC stage stops before the queue overflows. It discards its contents on a pipeline flush and stops accepting fetches after a faulting PC until the next flush.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  exception flush or branch redirect; drops all entries.
- in_valid  in  1  fetch response valid; pc, inst and exception fields are aligned.
- in_pc  in  32  fetched PC.
- in_inst  in  32  instruction word from the instruction ROM.
- in_is_exception  in  5  per-stage exception flags: bit4 is interrupt, bit3 is ADEF.
- in_exception_cause  in  35  five 7-bit cause codes, same order as the flags.
- in_ready  out  1  queue can accept a push.
- pause_req  out  1  stall request to the PC stage, fed into ctrl.pause[0].
- out_valid  out  1  head entry valid toward ID.
- out_ready  in  1  ID accepts the head entry.
- out_pc, out_inst  out  32 each  head entry fields.
- out_is_exception  out  5  head entry exception flags.
- out_exception_cause  out  35  head entry cause codes.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & (state == NORMAL).
- out_valid = (count != 0) & ~flush.
- Storage is a circular buffer:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
  - count increments on push only and decrements on pop only.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
- Exception entries: if in_is_exception != 0 on a push, the entry stores NOP_INST (32'h0340_0000) in place of in_inst. PC, flags and causes are stored unchanged.
- The state machine has two states, NORMAL and EXC_HOLD:
  - NORMAL → EXC_HOLD on a push with in_is_exception != 0.
  - EXC_HOLD → NORMAL on flush.
  - While in EXC_HOLD, in_ready = 0 and pops continue normally.
- pause_req = (count >= DEPTH-1) | (state == EXC_HOLD). This covers the one-cycle ROM latency, so at most one response is in flight when the stall takes effect.
- Boundary cases:
  - Full: in_ready = 0 even if pop is high in the same cycle. There is no full-bypass path.
  - Empty: no fall-through. A push appears at the outputs one cycle later at the earliest.
  - Flush:
    - pointers and count are 0 and state is NORMAL in the next cycle;
    - a same-cycle push is discarded;
    - out_valid is 0 during the flush cycle.
  - flush and rst together: rst dominates; the results are the same.
  - in_valid while in_ready = 0: the response is dropped. Correct operation relies on pause_req being honoured.

## Timing
- Reset values:
  - count 0, out_valid 0, pause_req 0, state NORMAL;
  - in_ready 1 (combinational, from count 0 and state NORMAL);
  - storage cleared to 0, so all out_* data fields read 0.
- Latency from push to out_valid: 1 cycle.
- Sustained throughput: 1 entry per cycle when out_ready = 1.
- out_* data is a combinational read of mem[rd_ptr]. ID registers it.
- Timing of each output:
  - pause_req and count are derived combinationally from registered count and state.
  - in_ready is combinational from count and state only, with no input-to-output path.
  - out_valid additionally depends combinationally on flush.

## Structure
- Additions to the shared pipeline_types package:
  - fetch_entry_t struct: pc, inst, is_exception[4:0], exception_cause[34:0];
  - constant NOP_INST;
  - constant EXC_CAUSE_W = 7.
- Exception code constants come from the existing CSR defines header.
- One sub-module: fetch_buffer_mem.
  - DEPTH × fetch_entry_t register array;
  - synchronous write and reset clear;
  - asynchronous read.
  - The pointers, state machine and handshake logic live in the top module.

## Test plan
1. Reset, then push PCs 0x100, 0x104, 0x108 with out_ready = 0.
   - count reaches 3 and pause_req goes high at count 3.
   - After out_ready = 1, pops return 0x100, 0x104, 0x108 in order on consecutive cycles.
2. Fill to 4 entries, then assert push and pop in the same cycle.
   - The push is refused (in_ready = 0), count goes to 3, and the head advances.
3. Stream 10 entries with out_ready = 1 and DEPTH = 4.
   - Pointers wrap correctly, output order matches input, and out_valid has no bubbles after the first cycle.
4. Push PC 0x10A with ADEF set.
   - The stored inst is 0x0340_0000 and the state becomes EXC_HOLD, so in_ready = 0 and pause_req = 1.
   - After flush: count 0, in_ready = 1, state NORMAL.
5. With 2 entries queued, assert flush together with a push of 0x200.
   - Next cycle count = 0 and out_valid = 0, and 0x200 never appears at the outputs.
6. Assert rst with 3 entries queued and the state in EXC_HOLD.
   - Next cycle: count 0, state NORMAL, out_pc 0, pause_req 0.
